// File: rtl/dot_engine_arbiter.sv
// Round-robin arbiter sharing one 16-element 8-bit dot-product engine among NREQ requesters.
// Optional DOT_DONE_CHECK_EN: flag a sticky err if the engine has not signalled done at result capture.
module dot_engine_arbiter #(
    parameter int NREQ       = 4,
    parameter int ENGINE_LAT = 17,
    parameter int IDW        = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*128-1:0]   req_a,
    input  logic [NREQ*128-1:0]   req_b,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [15:0]           resp_data,
    output logic                  eng_start,
    output logic [127:0]          eng_a,
    output logic [127:0]          eng_b,
    input  logic [15:0]           eng_c,
    input  logic                  eng_done,
    output logic                  err
);

    localparam int CW = $clog2(ENGINE_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [CW-1:0]   cnt;
    logic            found;
    logic [IDW-1:0]  sel;
    logic [IDW-1:0]  rr_next;

    // First requester at or after rr_ptr, wrapping at NREQ.
    always_comb begin
        int idx;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rr_ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = IDW'(idx);
            end
        end
    end

    assign rr_next = (resp_id == IDW'(NREQ - 1)) ? '0 : resp_id + 1'b1;
    assign busy    = (state != IDLE);

`ifdef DOT_DONE_CHECK_EN
    logic err_q;
    assign err = err_q;
`else
    logic unused_eng_done;
    assign unused_eng_done = eng_done;
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            cnt        <= '0;
            gnt        <= '0;
            eng_start  <= 1'b0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
            eng_a      <= '0;
            eng_b      <= '0;
`ifdef DOT_DONE_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            gnt       <= '0;
            eng_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        eng_a     <= req_a[sel*128 +: 128];
                        eng_b     <= req_b[sel*128 +: 128];
                        resp_id   <= sel;
                        gnt       <= NREQ'(1) << sel;
                        eng_start <= 1'b1;
                        cnt       <= '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // eng_done is sticky across operations, so the fixed count is the real timer.
                    if (cnt == CW'(ENGINE_LAT - 1)) begin
                        resp_data  <= eng_c;
                        resp_valid <= 1'b1;
                        state      <= RESP;
`ifdef DOT_DONE_CHECK_EN
                        if (!eng_done) err_q <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        rr_ptr     <= rr_next;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_engine_arbiter.sv
// Directed bench for dot_engine_arbiter with a behavioural 16-cycle MAC engine model.
// Build with DOT_DONE_CHECK_EN defined to exercise the sticky err path.
module tb_dot_engine_arbiter;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [3:0]     req;
    logic [511:0]   req_a, req_b;
    logic [3:0]     gnt;
    logic           busy, resp_valid, resp_ready;
    logic [1:0]     resp_id;
    logic [15:0]    resp_data, eng_c;
    logic           eng_start, eng_done, err;
    logic [127:0]   eng_a, eng_b;

    int ntests = 0;
    int nfail  = 0;

    logic [127:0] opa [4];
    logic [127:0] opb [4];
    logic [15:0]  exp_d [4];

    dot_engine_arbiter #(.NREQ(4), .ENGINE_LAT(17), .IDW(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .busy(busy), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data), .eng_start(eng_start),
        .eng_a(eng_a), .eng_b(eng_b), .eng_c(eng_c), .eng_done(eng_done), .err(err)
    );

    always #5 clk = ~clk;

    // Engine: samples start, then one MAC per cycle for 16 cycles; done is sticky until next start.
    logic [15:0] acc;
    logic [4:0]  k;
    logic        run, done, nodone;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0; k <= '0; run <= 1'b0; done <= 1'b0;
        end else if (eng_start) begin
            acc <= '0; k <= '0; run <= 1'b1; done <= 1'b0;
        end else if (run) begin
            acc <= acc + 16'(eng_a[k*8 +: 8]) * 16'(eng_b[k*8 +: 8]);
            k   <= k + 1'b1;
            if (k == 5'd15) begin
                run  <= 1'b0;
                done <= 1'b1;
            end
        end
    end
    assign eng_c    = acc;
    assign eng_done = done & ~nodone;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        ntests++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation from IDLE: selection edge X, response at X+18, stall cycles, accept.
    task automatic op(input string tag, input logic [3:0] r, input logic [1:0] eid,
                      input bit hold, input int stall);
        logic [3:0] eg;
        eg  = 4'b0001 << eid;
        req = r;
        tick();
        chk({tag, "_gnt"}, gnt, eg);
        chk({tag, "_start"}, eng_start, 1'b1);
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_eng_a"}, eng_a, opa[eid]);
        chk({tag, "_eng_b"}, eng_b, opb[eid]);
        if (!hold) req = 4'b0000;
        tick();
        chk({tag, "_gnt_pulse"}, {gnt, eng_start}, 5'b0);
        repeat (16) tick();
        chk({tag, "_valid_early"}, resp_valid, 1'b0);
        tick();
        chk({tag, "_valid"}, resp_valid, 1'b1);
        chk({tag, "_id"}, resp_id, eid);
        chk({tag, "_data"}, resp_data, exp_d[eid]);
        for (int s = 0; s < stall; s++) begin
            tick();
            chk({tag, "_stall_vld"}, resp_valid, 1'b1);
            chk({tag, "_stall_id"}, resp_id, eid);
            chk({tag, "_stall_data"}, resp_data, exp_d[eid]);
            chk({tag, "_stall_gnt"}, {gnt, eng_start}, 5'b0);
        end
        resp_ready = 1'b1;
        tick();
        chk({tag, "_accept"}, {resp_valid, busy}, 2'b00);
        resp_ready = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_gnt"}, gnt, 4'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_vld"}, resp_valid, 1'b0);
        chk({tag, "_id"}, resp_id, 2'd0);
        chk({tag, "_data"}, resp_data, 16'h0);
        chk({tag, "_start"}, eng_start, 1'b0);
        chk({tag, "_eng_a"}, eng_a, 128'h0);
        chk({tag, "_eng_b"}, eng_b, 128'h0);
        chk({tag, "_err"}, err, 1'b0);
    endtask

    initial begin
        opa[0] = {16{8'h01}}; opb[0] = {16{8'h03}}; exp_d[0] = 16'h0030;
        opa[1] = {16{8'hFF}}; opb[1] = {16{8'hFF}}; exp_d[1] = 16'hE010;
        opa[2] = {16{8'h01}}; opb[2] = {16{8'h02}}; exp_d[2] = 16'h0020;
        opa[3] = {16{8'h02}}; opb[3] = {16{8'h05}}; exp_d[3] = 16'h00A0;
        for (int r = 0; r < 4; r++) begin
            req_a[r*128 +: 128] = opa[r];
            req_b[r*128 +: 128] = opb[r];
        end
        req = 4'b0; resp_ready = 1'b0; nodone = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("reset");
        #21;
        rst_n = 1'b1;
        tick();
        chk_reset_vals("idle");

        // All requesting, ready immediately: 0,1,2,3,0 at 20-cycle spacing.
        op("rr0", 4'b1111, 2'd0, 1'b1, 0);
        op("rr1", 4'b1111, 2'd1, 1'b1, 0);
        op("rr2", 4'b1111, 2'd2, 1'b1, 0);
        op("rr3", 4'b1111, 2'd3, 1'b1, 0);
        op("rr4", 4'b1111, 2'd0, 1'b1, 0);
        // rr_ptr=1: only req[2] -> 32.
        op("single2", 4'b0100, 2'd2, 1'b0, 0);
        // rr_ptr=3: requester 1 with 0xFF operands wraps mod 2^16.
        op("wrap1", 4'b0010, 2'd1, 1'b0, 0);
        // rr_ptr=2: backpressure 5 cycles, then grant goes to 3.
        op("stall", 4'b1111, 2'd2, 1'b1, 5);
        op("after_stall", 4'b1111, 2'd3, 1'b1, 0);
        // Lone requester 0 regranted after wrapping through rr_ptr.
        op("lone_a", 4'b0001, 2'd0, 1'b0, 0);
        op("lone_b", 4'b0001, 2'd0, 1'b0, 0);

        // Abort mid-WAIT (counter=8); rr_ptr=1 beforehand, must return to 0.
        req = 4'b0100;
        tick();
        chk("abort_gnt", gnt, 4'b0100);
        req = 4'b0000;
        repeat (9) tick();
        chk("abort_busy_pre", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("abort");
        #3;
        rst_n = 1'b1;
        tick();
        op("post_reset", 4'b1111, 2'd0, 1'b0, 0);

`ifdef DOT_DONE_CHECK_EN
        nodone = 1'b1;
        op("nodone", 4'b0010, 2'd1, 1'b0, 0);
        chk("err_set", err, 1'b1);
        nodone = 1'b0;
        op("err_sticky_op", 4'b0100, 2'd2, 1'b0, 0);
        chk("err_sticky", err, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("err_cleared", err, 1'b0);
        #3;
        rst_n = 1'b1;
        tick();
`else
        chk("err_tied", err, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got hang expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dot_engine_arbiter.md
Name: dot_engine_arbiter

Overview:
- Round-robin scheduler that shares one 16-element 8-bit dot-product engine (16-bit wrapping accumulator, one MAC per cycle) among NREQ requesters.
- Latches the winning requester's operand vectors and holds them stable for the whole operation.
- Pulses the engine start, times completion with a fixed-latency counter, then returns the 16-bit result tagged with the requester ID over a valid/ready response channel.
- Sits between the NPU command front-end and the dot-product datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ENGINE_LAT, 17, cycles from the engine sampling start to its result being final and stable.
- IDW, 2, requester ID width; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request level
- req_a  in  NREQ*128  operand A per requester; 16 bytes, element k at bits [k*8+7:k*8] of slice r
- req_b  in  NREQ*128  operand B per requester, same packing
- gnt  out  NREQ  one-hot grant, one-cycle pulse
- busy  out  1  high when state is not IDLE
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_id  out  IDW  requester index of result
- resp_data  out  16  dot-product result
- eng_start  out  1  engine start pulse
- eng_a  out  128  latched operand A to engine
- eng_b  out  128  latched operand B to engine
- eng_c  in  16  engine accumulator
- eng_done  in  1  engine done; sticky in the engine, so not used for timing
- err  out  1  sticky completion-check error; optional feature only, otherwise tied 0

Behaviour:
- Reset (async): state=IDLE, rr_ptr=0, gnt=0, eng_start=0, resp_valid=0, resp_id=0, resp_data=0, eng_a=0, eng_b=0, err=0, counter=0.
- A reset in any state aborts the operation and discards the result. The engine shares rst_n.
- IDLE:
  - If req != 0, select the first set bit searching from rr_ptr upward, wrapping at NREQ.
  - At that edge: latch that requester's req_a/req_b into eng_a/eng_b, latch resp_id, register gnt one-hot, go to ISSUE.
  - If req == 0, stay in IDLE.
- ISSUE (1 cycle): gnt high for this cycle only; eng_start=1 for this cycle only; counter cleared; next state WAIT.
- WAIT:
  - Counter increments each cycle.
  - When counter == ENGINE_LAT-1: capture eng_c into resp_data, set resp_valid, go to RESP.
  - WAIT lasts exactly ENGINE_LAT cycles.
- RESP:
  - resp_valid, resp_id and resp_data are held stable until resp_valid && resp_ready.
  - On acceptance: resp_valid=0, rr_ptr=(resp_id+1) mod NREQ, go to IDLE.
- Requester rules:
  - Operands must be valid while req is high; they are sampled only at the selection edge.
  - A requester holds req until it sees gnt and may deassert req in the gnt cycle.
  - Dropping req before grant is a legal withdrawal.
  - req is ignored outside IDLE.
- Timing: if req is sampled at edge X, gnt and eng_start are high in cycle X..X+1 and resp_valid rises at edge X+18. Minimum issue interval is 20 cycles when resp_ready is held high.
- Arithmetic: the result is the engine's 16-bit modulo-2^16 sum, passed through unchanged. Operands are never modified.
- eng_a/eng_b change only at selection edges.
- A single requester is regranted when it is the only one requesting, after wrap through rr_ptr.

Optional Feature:
- Macro: DOT_DONE_CHECK_EN.
- Defined: at the capture edge, if eng_done==0, set err (sticky until reset). resp_data is still captured and the response proceeds normally.
- Undefined: err is tied 0 and eng_done is unused.

Test Plan:
- Only req[2] high, a=all 0x01, b=all 0x02 -> gnt=4'b0100 for one cycle; resp_valid at edge X+18 with resp_id=2, resp_data=32.
- Requester 1 with a=b=all 0xFF -> resp_data=0xE010 (1040400 mod 65536); no saturation.
- req=4'b1111 held, resp_ready=1 -> grant order 0,1,2,3,0, spaced 20 cycles apart; resp_id sequence matches.
- resp_ready low for 5 cycles in RESP -> resp_valid, resp_id and resp_data stable; no gnt or eng_start until acceptance; next grant goes to resp_id+1.
- rst_n pulsed low mid-WAIT (counter=8) -> all outputs return to reset values immediately; a fresh request afterwards completes with the correct result and resp_id.
- DOT_DONE_CHECK_EN defined, eng_done forced 0 -> err=1 after the capture edge and stays 1 through later operations until reset; undefined build -> err=0.
